// File: rtl/addr_sweep_controller.sv
// addr_sweep_controller: sweeps a [lo,hi] bin window over NUM_BANKS banks with ready backpressure; ADDR_SWEEP_REVERSE_EN adds a dir port for descending sweeps
module addr_sweep_controller #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int COLOR_RANGE   = 256,
  parameter int NUM_BANKS     = 2,
  parameter int BANK_WIDTH    = 1
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] lo_addr,
  input  logic [ADDRESS_WIDTH-1:0] hi_addr,
`ifdef ADDR_SWEEP_REVERSE_EN
  input  logic                     dir,
`endif
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [BANK_WIDTH-1:0]    bank,
  output logic                     addr_valid,
  output logic                     wreq,
  input  logic                     addr_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam int unsigned CMAX = COLOR_RANGE - 1;
  localparam logic [ADDRESS_WIDTH:0] STEP_UP = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH:0] STEP_DN = '1;
  state_t state, state_d;
  logic [ADDRESS_WIDTH-1:0] lo_q, hi_q, addr_q, lo_d, hi_d, addr_d, hi_clamp, first_addr;
  logic [ADDRESS_WIDTH:0] step;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic dir_in, dir_q, dir_d, ab_q, ab_d, err, last_addr, last_bank;
`ifdef ADDR_SWEEP_REVERSE_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif
  assign hi_clamp   = (32'(hi_addr) > CMAX) ? ADDRESS_WIDTH'(CMAX) : hi_addr;
  assign err        = lo_addr > hi_clamp;
  assign first_addr = dir_q ? hi_q : lo_q;
  // one bit wider so the ascending step past the top bin is seen as "past hi"
  assign step       = {1'b0, addr_q} + (dir_q ? STEP_DN : STEP_UP);
  assign last_addr  = dir_q ? (addr_q == lo_q) : (step > {1'b0, hi_q});
  assign last_bank  = bank_q == BANK_WIDTH'(NUM_BANKS - 1);
  always_comb begin
    state_d = state;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dir_d   = dir_q;
    addr_d  = '0;
    bank_d  = '0;
    ab_d    = 1'b0;
    if (state == IDLE) begin
      if (start && !abort) begin
        lo_d    = lo_addr;
        hi_d    = hi_clamp;
        dir_d   = dir_in;
        state_d = err ? FIN : RUN;
        ab_d    = err;
        addr_d  = err ? '0 : (dir_in ? hi_clamp : lo_addr);
      end
    end else if (state == RUN) begin
      addr_d = addr_q;
      bank_d = bank_q;
      if (abort || (addr_ready && last_addr && last_bank)) begin
        state_d = FIN;
        ab_d    = abort;
        addr_d  = '0;
        bank_d  = '0;
      end else if (addr_ready) begin
        addr_d = last_addr ? first_addr : step[ADDRESS_WIDTH-1:0];
        bank_d = last_addr ? bank_q + BANK_WIDTH'(1) : bank_q;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state  <= IDLE;
      lo_q   <= '0;
      hi_q   <= '0;
      dir_q  <= 1'b0;
      addr_q <= '0;
      bank_q <= '0;
      ab_q   <= 1'b0;
    end else begin
      state  <= state_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      dir_q  <= dir_d;
      addr_q <= addr_d;
      bank_q <= bank_d;
      ab_q   <= ab_d;
    end
  end
  assign addr       = addr_q;
  assign bank       = bank_q;
  assign addr_valid = state == RUN;
  assign wreq       = state == RUN;
  assign busy       = state == RUN;
  assign done       = state == FIN;
  assign aborted    = ab_q;
endmodule

// File: tb/tb_addr_sweep_controller.sv
// tb_addr_sweep_controller: table-driven sweeps checked against a beat scoreboard, plus reset/abort/clamp sequences
module tb_addr_sweep_controller;
  localparam int AW = 8, NB = 2, BW = 1;
`ifdef ADDR_SWEEP_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  logic clk = 1'b0;
  logic srst, start, abort, addr_ready, dir, addr_valid, wreq, busy, done, aborted;
  logic [AW-1:0] lo_addr, hi_addr, addr;
  logic [BW-1:0] bank;
  logic w_start, w_valid, w_wreq, w_busy, w_done, w_aborted;
  logic [8:0] w_lo, w_hi, w_addr;
  logic [0:0] w_bank;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  addr_sweep_controller #(.ADDRESS_WIDTH(AW), .COLOR_RANGE(256), .NUM_BANKS(NB), .BANK_WIDTH(BW)) dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort), .lo_addr(lo_addr), .hi_addr(hi_addr),
`ifdef ADDR_SWEEP_REVERSE_EN
    .dir(dir),
`endif
    .addr(addr), .bank(bank), .addr_valid(addr_valid), .wreq(wreq), .addr_ready(addr_ready),
    .busy(busy), .done(done), .aborted(aborted));

  addr_sweep_controller #(.ADDRESS_WIDTH(9), .COLOR_RANGE(256), .NUM_BANKS(1), .BANK_WIDTH(1)) dut_w9 (
    .clk(clk), .srst(srst), .start(w_start), .abort(abort), .lo_addr(w_lo), .hi_addr(w_hi),
`ifdef ADDR_SWEEP_REVERSE_EN
    .dir(1'b0),
`endif
    .addr(w_addr), .bank(w_bank), .addr_valid(w_valid), .wreq(w_wreq), .addr_ready(addr_ready),
    .busy(w_busy), .done(w_done), .aborted(w_aborted));

  typedef struct { logic [AW-1:0] a; logic [BW-1:0] b; } beat_t;
  typedef struct { int lo; int hi; bit dir; int rdy; int abort_at; int exp_beats; bit exp_aborted; int exp_lat; } vec_t;
  beat_t sb[$];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input vec_t v);
    int hi_c, acc, k;
    bit d, hold, got_done;
    beat_t e;
    logic [AW-1:0] pa;
    logic [BW-1:0] pb;
    hi_c = v.hi > 255 ? 255 : v.hi;
    d = v.dir & REV;
    sb.delete();
    if (v.lo <= hi_c)
      for (int b = 0; b < NB; b++)
        for (int i = 0; i <= hi_c - v.lo; i++)
          if (v.abort_at == 0 || sb.size() < v.abort_at) begin
            e.a = AW'(d ? hi_c - i : v.lo + i);
            e.b = BW'(b);
            sb.push_back(e);
          end
    start = 1'b1; lo_addr = AW'(v.lo); hi_addr = AW'(v.hi); dir = v.dir; abort = 1'b0; addr_ready = 1'b0;
    tick();
    start = 1'b0;
    acc = 0; k = 0; hold = 1'b0; got_done = 1'b0; pa = '0; pb = '0;
    while (k < 2000) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (hold && addr_valid) begin
        chk("hold_addr", 32'(addr), 32'(pa));
        chk("hold_bank", 32'(bank), 32'(pb));
      end
      addr_ready = v.rdy == 0 ? 1'b1 : v.rdy == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      abort = addr_valid && addr_ready && v.abort_at != 0 && acc + 1 == v.abort_at;
      if (addr_valid) chk("wreq_eq_valid", 32'(wreq), 32'(1));
      if (addr_valid && addr_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: got addr %0d bank %0d, required no beat", addr, bank);
        end else begin
          e = sb.pop_front();
          chk("beat_addr", 32'(addr), 32'(e.a));
          chk("beat_bank", 32'(bank), 32'(e.b));
        end
        acc++;
      end
      hold = addr_valid && !addr_ready;
      pa = addr; pb = bank;
      tick();
      k++;
    end
    chk("done_seen", 32'(got_done), 32'(1));
    chk("fin_aborted", 32'(aborted), 32'(v.exp_aborted));
    chk("fin_valid", 32'(addr_valid), 32'(0));
    chk("fin_busy", 32'(busy), 32'(0));
    chk("beat_count", 32'(acc), 32'(v.exp_beats));
    chk("sb_left", 32'(sb.size()), 32'(0));
    if (v.exp_lat >= 0) chk("done_latency", 32'(k), 32'(v.exp_lat));
    abort = 1'b0; addr_ready = 1'b0;
    tick();
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_aborted", 32'(aborted), 32'(0));
    chk("idle_addr", 32'(addr), 32'(0));
  endtask

  initial begin
    int k, acc, last;
    bit found;
    //          lo   hi  dir rdy abt beats abrt lat
    tbl[0] = '{0,   255, 0,  0,  0,  512,  0,   512};
    tbl[1] = '{10,  12,  0,  1,  0,  6,    0,   16};
    tbl[2] = '{30,  40,  0,  0,  5,  5,    1,   5};
    tbl[3] = '{20,  5,   0,  0,  0,  0,    1,   0};
    tbl[4] = '{3,   5,   1,  0,  0,  6,    0,   6};
    tbl[5] = '{7,   7,   0,  2,  0,  2,    0,   -1};
    tbl[6] = '{100, 110, 1,  1,  0,  22,   0,   64};
    tbl[7] = '{250, 255, 0,  2,  3,  3,    1,   -1};
    srst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0; dir = 1'b0;
    lo_addr = '0; hi_addr = '0; w_start = 1'b0; w_lo = '0; w_hi = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(addr_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_addr", 32'(addr), 32'(0));
    srst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) run_case(tbl[i]);
    // start together with abort in IDLE must not launch a run
    start = 1'b1; abort = 1'b1; lo_addr = 8'd1; hi_addr = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_valid", 32'(addr_valid), 32'(0));
    chk("sa_done", 32'(done), 32'(0));
    tick();
    chk("sa_busy", 32'(busy), 32'(0));
    // srst mid-run at bank1/addr100; a start pulse during RUN must not disturb the sweep
    start = 1'b1; lo_addr = 8'd0; hi_addr = 8'd255; addr_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0; found = 1'b0;
    while (k < 700) begin
      if (addr_valid && bank == 1'b1 && addr == 8'd100) begin
        found = 1'b1;
        break;
      end
      start = k == 3; lo_addr = 8'd200;
      tick();
      k++;
    end
    start = 1'b0;
    chk("srst_reach", 32'(k), 32'(356));
    chk("srst_found", 32'(found), 32'(1));
    srst = 1'b1;
    tick();
    srst = 1'b0; addr_ready = 1'b0;
    chk("srst_addr", 32'(addr), 32'(0));
    chk("srst_bank", 32'(bank), 32'(0));
    chk("srst_valid", 32'(addr_valid), 32'(0));
    chk("srst_wreq", 32'(wreq), 32'(0));
    chk("srst_busy", 32'(busy), 32'(0));
    chk("srst_done", 32'(done), 32'(0));
    chk("srst_aborted", 32'(aborted), 32'(0));
    run_case('{5, 6, 0, 0, 0, 4, 0, 4});
    // hi beyond COLOR_RANGE-1 on a 9-bit instance clamps to 255
    w_start = 1'b1; w_lo = 9'd250; w_hi = 9'd300; addr_ready = 1'b1;
    tick();
    w_start = 1'b0;
    k = 0; acc = 0; last = -1; found = 1'b0;
    while (k < 40) begin
      if (w_done) begin
        found = 1'b1;
        break;
      end
      if (w_valid) begin
        chk("w9_addr", 32'(w_addr), 32'(250 + acc));
        last = int'(w_addr);
        acc++;
      end
      tick();
      k++;
    end
    chk("w9_done", 32'(found), 32'(1));
    chk("w9_beats", 32'(acc), 32'(6));
    chk("w9_last", 32'(last), 32'(255));
    chk("w9_aborted", 32'(w_aborted), 32'(0));
    addr_ready = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
